// File: rtl/fd_issue_ctrl.sv
// Issue/sequencing controller for the dual-slot F/D pipe register and PC advance.
// Optional performance counters are built when PERF_CNT_EN is defined.
module fd_issue_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic             load_use,
  input  logic             md_busy,
  input  logic             dep_hazard,
  output logic             fd_we,
  output logic             fd_flush,
  output logic             issue_top,
  output logic             issue_bot,
  output logic [1:0]       pc_advance,
  output logic             pc_load,
  output logic             split_active,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] split_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SPLIT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // A single-cycle flush needs no FLUSH state; the redirect cycle itself is the bubble.
  localparam logic [3:0] FLUSH_RELOAD   = 4'(FLUSH_CYCLES - 1);
  localparam state_t     REDIRECT_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t     state_q, state_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic       stall;

  assign stall = load_use | md_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    fd_we      = 1'b0;
    fd_flush   = 1'b0;
    issue_top  = 1'b0;
    issue_bot  = 1'b0;
    pc_advance = 2'd0;
    pc_load    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (redirect) begin
          pc_load  = 1'b1;
          fd_flush = 1'b1;
          fcnt_d   = FLUSH_RELOAD;
          state_d  = REDIRECT_STATE;
        end else if (stall) begin
          state_d = RUN;
        end else if (dep_hazard) begin
          issue_top = 1'b1;
          state_d   = SPLIT;
        end else begin
          issue_top  = 1'b1;
          issue_bot  = 1'b1;
          fd_we      = 1'b1;
          pc_advance = 2'd2;
        end
      end

      SPLIT: begin
        if (redirect) begin
          pc_load  = 1'b1;
          fd_flush = 1'b1;
          fcnt_d   = FLUSH_RELOAD;
          state_d  = REDIRECT_STATE;
        end else if (stall) begin
          state_d = SPLIT;
        end else begin
          issue_bot  = 1'b1;
          fd_we      = 1'b1;
          pc_advance = 2'd2;
          state_d    = RUN;
        end
      end

      FLUSH: begin
        fd_flush = 1'b1;
        if (redirect) begin
          pc_load = 1'b1;
          fcnt_d  = FLUSH_RELOAD;
        end else if (fcnt_q <= 4'd1) begin
          fcnt_d  = 4'd0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end

      default: begin
        fcnt_d  = 4'd0;
        state_d = RUN;
      end
    endcase

    // Reset overrides everything so the pipe register is cleared without waiting for a clock.
    if (reset) begin
      fd_we      = 1'b0;
      fd_flush   = 1'b1;
      issue_top  = 1'b0;
      issue_bot  = 1'b0;
      pc_advance = 2'd0;
      pc_load    = 1'b0;
    end
  end

  assign split_active = (state_q == SPLIT);

`ifdef PERF_CNT_EN
  logic             stallEvt, splitEvt;
  logic [CNT_W-1:0] stallCnt_q, splitCnt_q, flushCnt_q;

  assign stallEvt = (state_q != FLUSH) & ~redirect & stall;
  assign splitEvt = (state_q == RUN) & ~redirect & ~stall & dep_hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt_q <= '0;
      splitCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stallEvt) stallCnt_q <= stallCnt_q + CNT_W'(1);
      if (splitEvt) splitCnt_q <= splitCnt_q + CNT_W'(1);
      if (pc_load)  flushCnt_q <= flushCnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stallCnt_q;
  assign split_cnt = splitCnt_q;
  assign flush_cnt = flushCnt_q;
`else
  assign stall_cnt = '0;
  assign split_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fd_issue_ctrl.sv
// Randomized bench for fd_issue_ctrl: three instances (FLUSH_CYCLES 1/2/3, one with a
// narrow counter to exercise wrap) checked against a pending-bot/flush-remaining model.
module tb_fd_issue_ctrl;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic redirect = 1'b0, loadUse = 1'b0, mdBusy = 1'b0, depHazard = 1'b0;

  logic       fdWe[3], fdFlush[3], issueTop[3], issueBot[3], pcLoad[3], splitActive[3];
  logic [1:0] pcAdvance[3];
  logic [3:0]  stallCnt0, splitCnt0, flushCnt0;
  logic [31:0] stallCnt1, splitCnt1, flushCnt1;
  logic [31:0] stallCnt2, splitCnt2, flushCnt2;

  int checkCount = 0;
  int passCount  = 0;

  // Model: a bot slot waiting to issue, and FLUSH bubbles still owed after this cycle.
  bit              botPending[3];
  int              flushLeft[3];
  longint unsigned mStall[3], mSplit[3], mFlush[3];

  always #5 clk = ~clk;

  fd_issue_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .redirect(redirect), .load_use(loadUse), .md_busy(mdBusy),
    .dep_hazard(depHazard), .fd_we(fdWe[0]), .fd_flush(fdFlush[0]), .issue_top(issueTop[0]),
    .issue_bot(issueBot[0]), .pc_advance(pcAdvance[0]), .pc_load(pcLoad[0]),
    .split_active(splitActive[0]), .stall_cnt(stallCnt0), .split_cnt(splitCnt0),
    .flush_cnt(flushCnt0));

  fd_issue_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .redirect(redirect), .load_use(loadUse), .md_busy(mdBusy),
    .dep_hazard(depHazard), .fd_we(fdWe[1]), .fd_flush(fdFlush[1]), .issue_top(issueTop[1]),
    .issue_bot(issueBot[1]), .pc_advance(pcAdvance[1]), .pc_load(pcLoad[1]),
    .split_active(splitActive[1]), .stall_cnt(stallCnt1), .split_cnt(splitCnt1),
    .flush_cnt(flushCnt1));

  fd_issue_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset), .redirect(redirect), .load_use(loadUse), .md_busy(mdBusy),
    .dep_hazard(depHazard), .fd_we(fdWe[2]), .fd_flush(fdFlush[2]), .issue_top(issueTop[2]),
    .issue_bot(issueBot[2]), .pc_advance(pcAdvance[2]), .pc_load(pcLoad[2]),
    .split_active(splitActive[2]), .stall_cnt(stallCnt2), .split_cnt(splitCnt2),
    .flush_cnt(flushCnt2));

  function automatic int fcOf(int k);
    return k + 1;
  endfunction

  function automatic int cwOf(int k);
    return (k == 0) ? 4 : 32;
  endfunction

  function automatic logic [31:0] obsStall(int k);
    case (k)
      0:       return {28'd0, stallCnt0};
      1:       return stallCnt1;
      default: return stallCnt2;
    endcase
  endfunction

  function automatic logic [31:0] obsSplit(int k);
    case (k)
      0:       return {28'd0, splitCnt0};
      1:       return splitCnt1;
      default: return splitCnt2;
    endcase
  endfunction

  function automatic logic [31:0] obsFlush(int k);
    case (k)
      0:       return {28'd0, flushCnt0};
      1:       return flushCnt1;
      default: return flushCnt2;
    endcase
  endfunction

  // Control bits packed as {we, flush, top, bot, advance[1:0], load, split}.
  function automatic logic [31:0] obsCtrl(int k);
    return {24'd0, fdWe[k], fdFlush[k], issueTop[k], issueBot[k], pcAdvance[k],
            pcLoad[k], splitActive[k]};
  endfunction

  function automatic longint unsigned bump(longint unsigned v, int w);
    return (v + 64'd1) % (64'd1 << w);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)",
                  tag, observed, expected, $time);
  endtask

  task automatic applyStimulus(input bit r, input bit rd, input bit lu, input bit md,
                               input bit dh);
    reset     = r;
    redirect  = rd;
    loadUse   = lu;
    mdBusy    = md;
    depHazard = dh;
  endtask

  // Inputs change 2 time units after the edge; everything is checked 2 units later.
  task automatic runCycle(input bit r, input bit rd, input bit lu, input bit md, input bit dh);
    logic [7:0] exp;
    bit         we, fl, top, bot, ld, spl;
    logic [1:0] adv;
    applyStimulus(r, rd, lu, md, dh);
    #2;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        botPending[k] = 1'b0;
        flushLeft[k]  = 0;
        mStall[k] = 0;
        mSplit[k] = 0;
        mFlush[k] = 0;
      end
      checkOutput($sformatf("d%0d.stall_cnt", k), obsStall(k), PERF ? 32'(mStall[k]) : 32'd0);
      checkOutput($sformatf("d%0d.split_cnt", k), obsSplit(k), PERF ? 32'(mSplit[k]) : 32'd0);
      checkOutput($sformatf("d%0d.flush_cnt", k), obsFlush(k), PERF ? 32'(mFlush[k]) : 32'd0);

      {we, fl, top, bot, ld, spl} = '0;
      adv = 2'd0;
      if (r) begin
        fl = 1'b1;
      end else begin
        spl = botPending[k];
        if (rd) begin
          fl = 1'b1;
          ld = 1'b1;
          flushLeft[k]  = fcOf(k) - 1;
          botPending[k] = 1'b0;
          mFlush[k]     = bump(mFlush[k], cwOf(k));
        end else if (flushLeft[k] > 0) begin
          fl = 1'b1;
          flushLeft[k]--;
        end else if (lu || md) begin
          mStall[k] = bump(mStall[k], cwOf(k));
        end else if (botPending[k]) begin
          bot = 1'b1;
          we  = 1'b1;
          adv = 2'd2;
          botPending[k] = 1'b0;
        end else if (dh) begin
          top = 1'b1;
          botPending[k] = 1'b1;
          mSplit[k]     = bump(mSplit[k], cwOf(k));
        end else begin
          top = 1'b1;
          bot = 1'b1;
          we  = 1'b1;
          adv = 2'd2;
        end
      end
      exp = {we, fl, top, bot, adv, ld, spl};
      checkOutput($sformatf("d%0d.ctrl", k), obsCtrl(k), {24'd0, exp});
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      botPending[k] = 1'b0;
      flushLeft[k]  = 0;
      mStall[k] = 0;
      mSplit[k] = 0;
      mFlush[k] = 0;
    end
    @(posedge clk);
    #2;

    // Reset held with idle inputs, then free-running dual issue.
    repeat (2) runCycle(1, 0, 0, 0, 0);
    repeat (3) runCycle(0, 0, 0, 0, 0);
    // Single dep_hazard pulse: split then back to dual issue.
    runCycle(0, 0, 0, 0, 1);
    repeat (2) runCycle(0, 0, 0, 0, 0);
    // Lone redirect pulse.
    runCycle(0, 1, 0, 0, 0);
    repeat (4) runCycle(0, 0, 0, 0, 0);
    // md_busy stalls the pending bot for four cycles.
    runCycle(0, 0, 0, 0, 1);
    repeat (4) runCycle(0, 0, 0, 1, 0);
    repeat (2) runCycle(0, 0, 0, 0, 0);
    // Redirect with load_use while bot is pending.
    runCycle(0, 0, 0, 0, 1);
    runCycle(0, 1, 1, 0, 0);
    repeat (4) runCycle(0, 0, 0, 0, 0);
    // Back-to-back redirects restart the flush window.
    runCycle(0, 1, 0, 0, 0);
    runCycle(0, 1, 0, 0, 0);
    repeat (4) runCycle(0, 0, 0, 0, 0);
    // Reset arriving mid-SPLIT and mid-FLUSH.
    runCycle(0, 0, 0, 0, 1);
    runCycle(1, 0, 0, 0, 0);
    runCycle(0, 0, 0, 0, 0);
    runCycle(0, 1, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0);
    repeat (2) runCycle(0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      runCycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 35);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fd_issue_ctrl.md
Name: fd_issue_ctrl

Overview:
Controller that sequences the dual-slot (top/bot) fetch/decode pipe register and the PC advance logic.
- Each cycle it decides one of: dual-issue the fetched pair, split it (top alone, then bot alone), stall, or flush after a redirect from execute.
- It drives the pipe register's write-enable and flush (synchronous clear) and tells the PC unit how far to advance.
- Sits between the hazard/branch logic and the fetch stage.

Parameters:
FLUSH_CYCLES, 1, bubble cycles the pipe register is held cleared after a redirect (1..15)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
redirect  input  1  execute stage resolved taken branch/jump; pair in F/D is wrong-path
load_use  input  1  decode reports load-use hazard on the current issue slot(s)
md_busy  input  1  multiply/divide unit busy; the issue slot needs it
dep_hazard  input  1  bot instruction depends on top (RAW/WAW), or both need one unit
fd_we  output  1  write-enable to the F/D pipe register
fd_flush  output  1  clear to the F/D pipe register (to nop/0)
issue_top  output  1  top slot valid into decode this cycle
issue_bot  output  1  bot slot valid into decode this cycle
pc_advance  output  2  PC increment in instructions: 0 or 2
pc_load  output  1  PC takes redirect target this cycle
split_active  output  1  controller is in SPLIT
stall_cnt  output  CNT_W  cycles stalled (perf)
split_cnt  output  CNT_W  pairs split (perf)
flush_cnt  output  CNT_W  redirects taken (perf)

Behaviour:
- States: RUN, SPLIT, FLUSH. Flush counter fcnt is 4 bits.
- Reset (async, immediate): state=RUN, fcnt=0, counters=0.
- While reset is high, outputs are forced: fd_we=0, fd_flush=1, issue_top=0, issue_bot=0, pc_advance=0, pc_load=0.
- All other outputs are combinational from state and inputs; state updates on the rising edge.
- Priority in every state: redirect > (load_use|md_busy) > dep_hazard.
- RUN:
  - redirect: pc_load=1, fd_flush=1, fd_we=0, no issue; fcnt<=FLUSH_CYCLES-1; go to FLUSH if FLUSH_CYCLES>1, else stay in RUN.
  - Stall (load_use|md_busy): fd_we=0, no issue, pc_advance=0; stay in RUN.
  - dep_hazard: issue_top=1, issue_bot=0, fd_we=0, pc_advance=0; go to SPLIT.
  - Otherwise: issue_top=issue_bot=1, fd_we=1, pc_advance=2.
- SPLIT (top already issued, bot pending):
  - redirect: same as in RUN; bot is dropped.
  - Stall: hold all outputs 0; stay in SPLIT.
  - Otherwise (dep_hazard ignored): issue_bot=1, issue_top=0, fd_we=1, pc_advance=2; go to RUN.
- FLUSH:
  - Each cycle: fd_flush=1, fd_we=0, no issue, pc_advance=0.
  - fcnt decrements; at fcnt==0, go to RUN at the next edge.
  - A new redirect in FLUSH: pc_load=1, fcnt<=FLUSH_CYCLES-1, stay in FLUSH.
- Invariants:
  - fd_we and fd_flush are never both 1.
  - pc_load=1 only with fd_flush=1.
  - issue_top and issue_bot are never both 1 outside RUN.
- Reset mid-SPLIT or mid-FLUSH: the pending bot is abandoned; state returns to RUN.

Optional Feature:
PERF_CNT_EN
- Defined: stall_cnt, split_cnt and flush_cnt are active.
  - stall_cnt increments on every stall cycle (RUN or SPLIT).
  - split_cnt increments on each RUN->SPLIT transition.
  - flush_cnt increments on each cycle with pc_load=1.
  - All three wrap modulo 2^CNT_W and clear on reset.
- Undefined: the counter registers are not built; stall_cnt, split_cnt and flush_cnt are tied to 0. Ports remain present.

Test Plan:
- Reset asserted mid-cycle with all inputs 0 -> outputs go immediately to fd_we=0, fd_flush=1. After release: fd_we=1, issue_top=issue_bot=1, pc_advance=2 every cycle.
- dep_hazard=1 for one cycle in RUN -> cycle 0: issue_top=1, fd_we=0, pc_advance=0. Cycle 1: issue_bot=1, fd_we=1, pc_advance=2, split_active=1. Cycle 2: back to RUN.
- FLUSH_CYCLES=3, redirect pulse -> pc_load=1 for 1 cycle; fd_flush=1 for exactly 3 cycles; dual issue resumes on cycle 3. flush_cnt=1 with PERF_CNT_EN.
- In SPLIT, md_busy=1 for 4 cycles then 0 -> no issue and fd_we=0 for 4 cycles, then issue_bot=1. stall_cnt=4, split_cnt=1.
- In SPLIT, redirect together with load_use -> pc_load=1, fd_flush=1; bot never issues; state goes to FLUSH (or RUN if FLUSH_CYCLES=1).
- Redirect during FLUSH (FLUSH_CYCLES=2, second redirect 1 cycle later) -> fd_flush=1 for 3 consecutive cycles total; pc_load=1 twice.
